// File: rtl/ebike_ui_pkg.sv
// Shared e-bike UI types: assist level, LED bar/acknowledge patterns and the
// indicator FSM state encoding.
package ebike_ui_pkg;

  typedef logic [1:0] assist_t;

  localparam assist_t ASSIST_RST = 2'b10;

  typedef enum logic [1:0] {
    StSteady = 2'd0,
    StFlOn   = 2'd1,
    StFlOff  = 2'd2
  } led_st_t;

  function automatic logic [2:0] bar_pat(assist_t s);
    logic [2:0] pat;
    unique case (s)
      2'd0:    pat = 3'b000;
      2'd1:    pat = 3'b001;
      2'd2:    pat = 3'b011;
      default: pat = 3'b111;
    endcase
    return pat;
  endfunction

  // "Assist off" lights every LED so the change is still visible.
  function automatic logic [2:0] ack_pat(assist_t s);
    return (s == 2'd0) ? 3'b111 : bar_pat(s);
  endfunction

endpackage

// File: rtl/assist_led_drv_if.sv
// Setting/LED bundle between the mode interface and the assist indicator.
// The bright field exists only when ASSIST_LED_PWM_EN is defined.
interface assist_led_drv_if #(
  parameter int unsigned PWM_W = 8
);
  import ebike_ui_pkg::*;

  assist_t    setting;
  logic [2:0] led;
  logic       busy;

`ifdef ASSIST_LED_PWM_EN
  logic [PWM_W-1:0] bright;

  modport master (output setting, output bright, input led, input busy);
  modport slave  (input setting, input bright, output led, output busy);
`else
  logic unused_pwm_w;
  assign unused_pwm_w = ^PWM_W;

  modport master (output setting, input led, input busy);
  modport slave  (input setting, output led, output busy);
`endif

endinterface

// File: rtl/led_pwm.sv
// Free-running PWM counter and brightness compare; gate is high during the lit
// part of each 2^PWM_W-cycle period, and always high at full brightness.
module led_pwm #(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] bright,
  output logic             gate
);

  logic [PWM_W-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_q + PWM_W'(1);
    end
  end

  assign gate = (pc_q < bright) | (&bright);

endmodule

// File: rtl/assist_led_drv.sv
// Assist-level LED bar driver with change-acknowledge flashing.
// Optional steady-display PWM dimming is enabled by ASSIST_LED_PWM_EN.
module assist_led_drv
  import ebike_ui_pkg::*;
#(
  parameter int unsigned BLINK_CYC = 2_500_000,
  parameter int unsigned BLINK_CNT = 3,
  parameter int unsigned PWM_W     = 8
) (
  input logic             clk,
  input logic             rst,
  assist_led_drv_if.slave bus
);

  localparam int unsigned TmrW = (BLINK_CYC > 2) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned NflW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

  led_st_t         state_q, state_d;
  assist_t         set_q;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [NflW-1:0] nfl_q, nfl_d;
  logic [2:0]      led_q, led_d;
  logic            busy_q, busy_d;
  logic            chg;
  logic            tmr_last;
  logic            nfl_last;
  logic            gate;

  assign chg      = (bus.setting != set_q);
  assign tmr_last = (tmr_q == TmrW'(BLINK_CYC - 1));
  assign nfl_last = (nfl_q == NflW'(BLINK_CNT - 1));

`ifdef ASSIST_LED_PWM_EN
  led_pwm #(
    .PWM_W (PWM_W)
  ) u_led_pwm (
    .clk    (clk),
    .rst    (rst),
    .bright (bus.bright),
    .gate   (gate)
  );
`else
  logic unused_pwm_w;
  assign unused_pwm_w = ^PWM_W;
  assign gate         = 1'b1;
`endif

  // A new setting always wins over timer expiry and restarts the acknowledge.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    nfl_d   = nfl_q;
    if (chg) begin
      state_d = StFlOn;
      tmr_d   = '0;
      nfl_d   = '0;
    end else begin
      unique case (state_q)
        StSteady: begin
          tmr_d = '0;
        end
        StFlOn: begin
          if (tmr_last) begin
            state_d = StFlOff;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
        StFlOff: begin
          if (tmr_last) begin
            tmr_d = '0;
            if (nfl_last) begin
              state_d = StSteady;
            end else begin
              nfl_d   = nfl_q + NflW'(1);
              state_d = StFlOn;
            end
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
        default: begin
          state_d = StSteady;
          tmr_d   = '0;
          nfl_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the current state, hence one cycle behind it.
  always_comb begin
    led_d  = 3'b000;
    busy_d = 1'b0;
    unique case (state_q)
      StSteady: led_d = bar_pat(set_q) & {3{gate}};
      StFlOn: begin
        led_d  = ack_pat(set_q);
        busy_d = 1'b1;
      end
      StFlOff: busy_d = 1'b1;
      default: begin
        led_d  = 3'b000;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSteady;
      set_q   <= ASSIST_RST;
      tmr_q   <= '0;
      nfl_q   <= '0;
      led_q   <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= bus.setting;
      tmr_q   <= tmr_d;
      nfl_q   <= nfl_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;

endmodule
